// File: rtl/microtile_pkg.sv
// Shared types and constants for the microtile exerciser: FSM states,
// signature geometry and the MSB-first CRC-16 byte update.
package microtile_pkg;

    localparam int unsigned SIG_W       = 16;
    localparam int unsigned NUM_VECTORS = 256;

    localparam logic [SIG_W-1:0] DEFAULT_POLY = 16'h1021;
    localparam logic [SIG_W-1:0] DEFAULT_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // Non-reflected CRC, data MSB first, no final XOR.
    function automatic logic [SIG_W-1:0] crc_byte(
        input logic [SIG_W-1:0] sig,
        input logic [7:0]       data,
        input logic [SIG_W-1:0] poly
    );
        logic [SIG_W-1:0] s;
        logic [7:0]       d;
        logic             fb;
        s = sig;
        d = data;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = s[SIG_W-1] ^ d[7];
            s  = {s[SIG_W-2:0], 1'b0} ^ (fb ? poly : '0);
            d  = {d[6:0], 1'b0};
        end
        return s;
    endfunction

endpackage

// File: rtl/crc16_byte_step.sv
// Combinational one-byte CRC-16 signature update.
module crc16_byte_step
    import microtile_pkg::*;
#(
    parameter logic [SIG_W-1:0] POLY = DEFAULT_POLY
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [7:0]       data,
    output logic [SIG_W-1:0] next_sig
);

    always_comb begin
        next_sig = crc_byte(sig, data, POLY);
    end

endmodule

// File: rtl/microtile_exerciser.sv
// Drives all 256 ui_in vectors into a microtile, samples uo_out after a
// programmable settle time, streams the samples and signs them with a CRC-16.
module microtile_exerciser
    import microtile_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 2,
    parameter logic [SIG_W-1:0] SIG_POLY      = DEFAULT_POLY,
    parameter logic [SIG_W-1:0] SIG_INIT      = DEFAULT_INIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic [7:0]       uo_out,
    output logic [7:0]       ui_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic             cap_valid,
    output logic [7:0]       cap_idx,
    output logic [7:0]       cap_data
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LAST_VEC    = 8'(NUM_VECTORS - 1);

    state_t           state, state_nxt;
    logic [7:0]       vec;
    logic [7:0]       cnt;
    logic [SIG_W-1:0] exp_q;
    logic [SIG_W-1:0] sig_nxt;

    crc16_byte_step #(.POLY(SIG_POLY)) u_crc (
        .sig      (signature),
        .data     (uo_out),
        .next_sig (sig_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SETTLE;
            SETTLE:     if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
            SAMPLE:     state_nxt = (vec == LAST_VEC) ? DONE : SETTLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= '0;
            cnt       <= '0;
            exp_q     <= '0;
            ui_in     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= SIG_INIT;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            cap_data  <= '0;
        end else begin
            cap_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec       <= '0;
                        cnt       <= '0;
                        ui_in     <= '0;
                        signature <= SIG_INIT;
                        exp_q     <= expected_sig;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                SETTLE: cnt <= cnt + 8'd1;
                SAMPLE: begin
                    signature <= sig_nxt;
                    cap_valid <= 1'b1;
                    cap_data  <= uo_out;
                    cap_idx   <= vec;
                    // pass compares the post-update signature so it is valid with done
                    if (vec == LAST_VEC) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (sig_nxt == exp_q);
                    end else begin
                        vec   <= vec + 8'd1;
                        ui_in <= vec + 8'd1;
                        cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
